fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Drain stage sitting directly downstream of the team's synchronous FIFO (fifo). It pops bytes through the FIFO's rd/empty/data_out read port and serialises each byte onto a UART-style line: start bit, data bits LSB first, then stop bit(s). Fixed baud via a clock divider. Single clock domain, shared with the FIFO.

Parameters:
WIDTH, 8, data bits per frame; equals the FIFO's WIDTH.
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 2.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  transmit enable; gates only the start of new frames
fifo_empty  input  1  FIFO empty flag
fifo_data  input  WIDTH  FIFO data_out; valid the cycle after fifo_rd
fifo_rd  output  1  FIFO read strobe; one-cycle pulse per byte
tx  output  1  serial line; idle high
busy  output  1  high whenever state != IDLE
frame_done  output  1  one-cycle pulse on the final cycle of the last stop bit

Behaviour:
- Reset (async, rst_n=0): state=IDLE, tx=1, fifo_rd=0, busy=0, frame_done=0; baud counter, bit counter and shift register cleared.
- Reset mid-frame: tx returns to 1 immediately. The popped byte is discarded. No partial frame resumes after release.
- All outputs are registered. fifo_rd is never asserted while fifo_empty=1.
- FSM states: IDLE, LOAD, START, DATA, [PARITY], STOP.
- IDLE: if en && !fifo_empty, assert fifo_rd for exactly one cycle and go to LOAD. Otherwise hold.
- LOAD (1 cycle): capture fifo_data into the shift register, clear the baud counter, drive tx<=0, go to START.
- Latency: fifo_rd high in cycle N; tx falls in cycle N+2.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx = shift[0]. On each baud-counter wrap (count==CLKS_PER_BIT-1), shift right and increment the bit index. After WIDTH bits, go to STOP (or PARITY when enabled).
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done pulses on the last of these cycles, then the FSM goes to IDLE.
- Frame length: (1+WIDTH+STOP_BITS)*CLKS_PER_BIT cycles from tx falling edge to IDLE.
- Back-to-back frames: the IDLE cycle following STOP may issue the next fifo_rd. The minimum inter-frame gap is 2 extra cycles of tx=1 (IDLE+LOAD).
- Counter widths: baud counter $clog2(CLKS_PER_BIT) bits; bit index $clog2(WIDTH+1) bits. No overflow past the terminal count.
- en deasserted mid-frame: the current frame completes normally, and no further pops occur.
- fifo_empty rising mid-frame: ignored.
- en and fifo_empty sampled only in IDLE.

Optional Feature:
Macro FIFO_UART_TX_PARITY_EN.
- Defined: a PARITY state follows DATA and drives the even-parity bit (XOR of the WIDTH data bits) for CLKS_PER_BIT cycles. Frame length grows by CLKS_PER_BIT.
- Undefined: the PARITY state and parity logic are absent, and DATA goes directly to STOP.

Decomposition:
- Package fifo_uart_pkg: state enum typedef (tx_state_e), IDLE_LEVEL=1'b1, START_LEVEL=1'b0.
- One sub-module, baud_tick_gen: parameter CLKS_PER_BIT; inputs clk, rst_n, clear; output tick, a one-cycle pulse on counter wrap. The FSM uses tick to advance bits.

Test Plan:
1. Reset release with fifo_empty=1, en=1 → tx=1, fifo_rd=0, busy=0 for 100 cycles.
2. CLKS_PER_BIT=4, one byte 0xA5, en=1 → exactly one fifo_rd pulse; tx falls 2 cycles later. Bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total). frame_done pulses once.
3. 16 bytes written into the FIFO until full=1 → 16 fifo_rd pulses, 16 frames decoded in order matching the written data, 2-cycle gap between frames, then busy=0 with fifo_empty=1.
4. en dropped at the midpoint of the 0x3C frame with bytes queued → the frame finishes intact, no further fifo_rd. Re-raising en resumes with the next byte.
5. rst_n asserted during DATA bit 3 of 0xFF → tx=1 in the same cycle, state IDLE. After release the next queued byte transmits cleanly.
6. FIFO_UART_TX_PARITY_EN defined, bytes 0xA5 and 0x07 → parity bits 0 and 1 respectively. Frame length 44 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and line levels for the FIFO-drain UART transmitter.
// The PARITY state exists only when FIFO_UART_TX_PARITY_EN is defined.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read port of the upstream synchronous FIFO.
// master: the drain that pops; slave: the FIFO itself.
interface fifo_uart_tx_if #(
  parameter int WIDTH = 8
);

  logic             fifo_rd;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;

  modport master (
    output fifo_rd,
    input  fifo_empty,
    input  fifo_data
  );

  modport slave (
    input  fifo_rd,
    output fifo_empty,
    output fifo_data
  );

endinterface

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period divider: tick on the last cycle of each bit period.
// pre_tick flags the cycle before tick so callers can register outputs.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  assign tick     = (cnt == LAST);
  assign pre_tick = !clear && (cnt == PRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO and serialises them as UART frames.
// Optional even parity bit: define FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           frame_done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  tx_state_e        state_q, state_n;
  logic [WIDTH-1:0] shift_q, shift_n;
  logic [BW-1:0]    bit_q, bit_n;
  logic             tick, pre_tick, clear;
  logic             tx_d, done_d, rd_d;
`ifdef FIFO_UART_TX_PARITY_EN
  logic             parity_q;
`endif

  assign clear = (state_q == IDLE) || (state_q == LOAD);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_comb begin
    state_n = state_q;
    shift_n = shift_q;
    bit_n   = bit_q;
    case (state_q)
      IDLE: if (fifo.fifo_rd) state_n = LOAD;
      LOAD: begin
        shift_n = fifo.fifo_data;
        bit_n   = '0;
        state_n = START;
      end
      START: if (tick) state_n = DATA;
      DATA: if (tick) begin
        shift_n = shift_q >> 1;
        if (bit_q == LAST_BIT) begin
          bit_n   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end else begin
          bit_n = bit_q + BW'(1);
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: if (tick) state_n = STOP;
`endif
      STOP: if (tick) begin
        if (bit_q == LAST_STOP) begin
          state_n = IDLE;
        end else begin
          bit_n = bit_q + BW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered, so they decode the next state.
  always_comb begin
    tx_d = IDLE_LEVEL;
    case (state_n)
      START:  tx_d = START_LEVEL;
      DATA:   tx_d = shift_n[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: tx_d = parity_q;
`endif
      default: tx_d = IDLE_LEVEL;
    endcase
    done_d = (state_n == STOP) && (bit_n == LAST_STOP) && pre_tick;
    rd_d   = (state_n == IDLE) && en && !fifo.fifo_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_q        <= '0;
      tx           <= IDLE_LEVEL;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      fifo.fifo_rd <= 1'b0;
    end else begin
      state_q      <= state_n;
      shift_q      <= shift_n;
      bit_q        <= bit_n;
      tx           <= tx_d;
      busy         <= (state_n != IDLE);
      frame_done   <= done_d;
      fifo.fifo_rd <= rd_d;
    end
  end

`ifdef FIFO_UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (state_q == LOAD) begin
      parity_q <= ^fifo.fifo_data;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model plus line-level frame checker.
// Parity expectations follow FIFO_UART_TX_PARITY_EN.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int SB  = 1;

  logic clk, rst_n, en, tx, busy, frame_done;
  int   checks = 0;
  int   passed = 0;

  logic [7:0] q[$];
  logic [7:0] exp_q[$];

  fifo_uart_tx_if #(.WIDTH(8)) fifo ();

  fifo_uart_tx #(
    .WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo(fifo),
    .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Synchronous FIFO read port: data one cycle after rd, registered empty.
  always @(posedge clk) begin
    if (fifo.fifo_rd) begin
      chk("rd_while_empty", q.size() != 0, 1);
      if (q.size() != 0) fifo.fifo_data <= q.pop_front();
    end
    #1 fifo.fifo_empty = (q.size() == 0);
  end

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic check_frame(input int max_wait, input int drop_at,
                             output int rd_wait);
    logic [7:0] b;
    logic bits[$];
    logic seen;
    int cyc, done_cnt, done_pos, rd_extra, total;
    rd_wait = -1;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if (fifo.fifo_rd) begin
        rd_wait = i;
        break;
      end
    end
    chk("rd_seen", rd_wait >= 0, 1);
    if (rd_wait < 0) return;
    chk("exp_avail", exp_q.size() != 0, 1);
    if (exp_q.size() == 0) return;
    b = exp_q.pop_front();
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back((b >> i) & 8'd1);
`ifdef FIFO_UART_TX_PARITY_EN
    bits.push_back(^b);
`endif
    for (int i = 0; i < SB; i++) bits.push_back(1'b1);
    total = bits.size() * CPB;
    @(negedge clk);
    chk("rd_pulse_len", fifo.fifo_rd, 0);
    chk("load_tx_high", tx, 1);
    chk("load_busy", busy, 1);
    cyc = 0; done_cnt = 0; done_pos = -1; rd_extra = 0;
    for (int k = 0; k < bits.size(); k++) begin
      seen = bits[k];
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (cyc == drop_at) en = 1'b0;
        if (tx !== bits[k]) seen = tx;
        if (frame_done) begin
          done_cnt++;
          done_pos = cyc;
        end
        if (fifo.fifo_rd) rd_extra++;
        cyc++;
      end
      chk($sformatf("byte%02h_bit%0d", b, k), seen, bits[k]);
    end
    chk("frame_done_cnt", done_cnt, 1);
    chk("frame_done_pos", done_pos, total - 1);
    chk("rd_in_frame", rd_extra, 0);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_tx"}, tx, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, bad_tx, bad_rd, bad_busy, cnt;
    rst_n = 0;
    en = 1;
    fifo.fifo_empty = 1;
    fifo.fifo_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd", fifo.fifo_rd, 0);
    chk("rst_done", frame_done, 0);
    rst_n = 1;

    bad_tx = 0; bad_rd = 0; bad_busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (fifo.fifo_rd !== 1'b0) bad_rd++;
      if (busy !== 1'b0) bad_busy++;
    end
    chk("empty_tx_cycles", bad_tx, 0);
    chk("empty_rd_cycles", bad_rd, 0);
    chk("empty_busy_cycles", bad_busy, 0);

    push(8'hA5);
    check_frame(20, -1, w);
    check_idle("a5_end");
    push(8'h07);
    check_frame(20, -1, w);
    check_idle("07_end");

    for (int i = 0; i < 16; i++) push(8'($urandom_range(0, 255)));
    for (int i = 0; i < 16; i++) begin
      check_frame(i == 0 ? 20 : 4, -1, w);
      if (i > 0) chk("b2b_gap", w, 0);
    end
    check_idle("burst_end");
    chk("burst_empty", fifo.fifo_empty, 1);

    push(8'h3C);
    push(8'h81);
    push(8'h42);
    check_frame(20, 5 * CPB, w);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fifo.fifo_rd) cnt++;
    end
    chk("en_low_no_rd", cnt, 0);
    chk("en_low_busy", busy, 0);
    en = 1;
    check_frame(20, -1, w);
    check_frame(4, -1, w);
    chk("resume_gap", w, 0);
    check_idle("resume_end");

    push(8'hFF);
    push(8'h5A);
    w = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo.fifo_rd) begin
        w = i;
        break;
      end
    end
    chk("ff_rd_seen", w >= 0, 1);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    repeat (1 + 4 * CPB + 1) @(negedge clk);
    chk("ff_bit3_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_rd", fifo.fifo_rd, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    check_frame(20, -1, w);
    check_idle("post_rst_end");
    chk("final_empty", fifo.fifo_empty, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
